// File: rtl/icb_sram_slave.sv
// Aligned ICB slave onto a 1-cycle-latency single-port SRAM, with an in-order, credit-protected response FIFO.
// Optional feature macro: ICB_SRAM_RANGE_CHK_EN (flags addresses outside the SRAM window as errors).
module icb_sram_slave #(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DW        = WIDTH / 8,
    parameter int unsigned       SRAM_AW   = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               s_icb_cmd_valid,
    output logic               s_icb_cmd_ready,
    input  logic [ADDR_W-1:0]  s_icb_cmd_addr,
    input  logic               s_icb_cmd_read,
    input  logic [WIDTH-1:0]   s_icb_cmd_wdata,
    input  logic [DW-1:0]      s_icb_cmd_wmask,

    output logic               s_icb_rsp_valid,
    input  logic               s_icb_rsp_ready,
    output logic [WIDTH-1:0]   s_icb_rsp_rdata,
    output logic               s_icb_rsp_err,

    output logic               sram_cs,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [WIDTH-1:0]   sram_wdata,
    output logic [DW-1:0]      sram_wem,
    input  logic [WIDTH-1:0]   sram_rdata
);

    localparam int unsigned BSH   = (DW > 1) ? $clog2(DW) : 0;
    localparam int unsigned FA    = $clog2(RSP_DEPTH);
    localparam int unsigned PTR_W = FA + 1;

    logic              accept;
    logic              access;
    logic              range_err;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word;

    logic              inflight;
    logic              infl_read;
    logic              infl_err;
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  push_data;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  fifo_count;
    logic [PTR_W:0]    credits_used;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WIDTH:0]    fifo_mem [RSP_DEPTH];
    logic [WIDTH:0]    head;

    assign offset = s_icb_cmd_addr - BASE_ADDR;
    assign word   = offset >> BSH;

`ifdef ICB_SRAM_RANGE_CHK_EN
    assign range_err = (s_icb_cmd_addr < BASE_ADDR) || ((word >> SRAM_AW) != '0);
`else
    logic unused_word_hi;
    assign unused_word_hi = ^word;
    assign range_err      = 1'b0;
`endif

    assign accept = s_icb_cmd_valid & s_icb_cmd_ready;
    assign access = (s_icb_cmd_read || (s_icb_cmd_wmask != '0)) && !range_err;

    assign sram_cs    = accept & access;
    assign sram_we    = ~s_icb_cmd_read;
    assign sram_addr  = word[SRAM_AW-1:0];
    assign sram_wdata = s_icb_cmd_wdata;
    assign sram_wem   = s_icb_cmd_wmask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= 1'b0;
            infl_read <= 1'b0;
            infl_err  <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                infl_read <= s_icb_cmd_read;
                infl_err  <= range_err;
            end
        end
    end

    // The inflight slot already holds a credit, so the FIFO can never be full here.
    assign push      = inflight & ~fifo_full;
    assign push_data = (infl_read && !infl_err) ? sram_rdata : '0;
    assign pop       = s_icb_rsp_valid & s_icb_rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FA-1:0]] <= {infl_err, push_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FA] != rd_ptr[FA]) && (wr_ptr[FA-1:0] == rd_ptr[FA-1:0]);
    assign fifo_count = wr_ptr - rd_ptr;

    assign credits_used    = {1'b0, fifo_count} + {{PTR_W{1'b0}}, inflight};
    assign s_icb_cmd_ready = credits_used < (PTR_W + 1)'(RSP_DEPTH);

    assign head            = fifo_mem[rd_ptr[FA-1:0]];
    assign s_icb_rsp_valid = ~fifo_empty;
    assign s_icb_rsp_rdata = head[WIDTH-1:0];

`ifdef ICB_SRAM_RANGE_CHK_EN
    assign s_icb_rsp_err = head[WIDTH];
`else
    logic unused_err;
    assign unused_err    = head[WIDTH];
    assign s_icb_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_icb_sram_slave.sv
// Self-checking bench for icb_sram_slave: SRAM macro model, reference memory and in-order response scoreboard.
`timescale 1ns/1ps
module tb_icb_sram_slave;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DW        = 4;
    localparam int unsigned SRAM_AW   = 10;
    localparam int unsigned RSP_DEPTH = 4;
    localparam logic [31:0] BASE      = 32'h0000_1000;

    logic        clk;
    logic        rst_n;
    logic        s_icb_cmd_valid;
    logic        s_icb_cmd_ready;
    logic [31:0] s_icb_cmd_addr;
    logic        s_icb_cmd_read;
    logic [31:0] s_icb_cmd_wdata;
    logic [3:0]  s_icb_cmd_wmask;
    logic        s_icb_rsp_valid;
    logic        s_icb_rsp_ready;
    logic [31:0] s_icb_rsp_rdata;
    logic        s_icb_rsp_err;
    logic        sram_cs;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wem;
    logic [31:0] sram_rdata;

    int          errors = 0;
    int          checks = 0;
    int          epoch  = 0;
    int          stalls = 0;
    logic [32:0] sb [$];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] sram_mem [0:1023];

    icb_sram_slave #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .DW       (DW),
        .SRAM_AW  (SRAM_AW),
        .BASE_ADDR(BASE),
        .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_icb_cmd_valid(s_icb_cmd_valid),
        .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_addr (s_icb_cmd_addr),
        .s_icb_cmd_read (s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata),
        .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid),
        .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_rdata(s_icb_rsp_rdata),
        .s_icb_rsp_err  (s_icb_rsp_err),
        .sram_cs        (sram_cs),
        .sram_we        (sram_we),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_wem       (sram_wem),
        .sram_rdata     (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle-latency single-port SRAM macro
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wem[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: sim_time=%0t required=finish before 400000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic monitor();
        logic        hold;
        logic [32:0] held;
        logic [32:0] exp;
        int          hold_epoch;
        hold = 1'b0;
        held = '0;
        hold_epoch = 0;
        forever begin
            @(negedge clk);
            if (hold && hold_epoch == epoch) begin
                checks++;
                if (!s_icb_rsp_valid || {s_icb_rsp_err, s_icb_rsp_rdata} !== held) begin
                    errors++;
                    $display("FAIL rsp_hold: valid=%b payload=%h required valid=1 payload=%h",
                             s_icb_rsp_valid, {s_icb_rsp_err, s_icb_rsp_rdata}, held);
                end
            end
            hold       = rst_n && s_icb_rsp_valid && !s_icb_rsp_ready;
            held       = {s_icb_rsp_err, s_icb_rsp_rdata};
            hold_epoch = epoch;
            if (rst_n && dut.inflight) begin
                checks++;
                if (dut.fifo_full) begin
                    errors++;
                    $display("FAIL push_full: fifo_full=%b at push required=0", dut.fifo_full);
                end
            end
            if (rst_n && s_icb_rsp_valid && s_icb_rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got err=%b rdata=%h required=no response",
                             s_icb_rsp_err, s_icb_rsp_rdata);
                end else begin
                    exp = sb.pop_front();
                    if ({s_icb_rsp_err, s_icb_rsp_rdata} !== exp) begin
                        errors++;
                        $display("FAIL rsp_payload: err=%b rdata=%h required err=%b rdata=%h",
                                 s_icb_rsp_err, s_icb_rsp_rdata, exp[32], exp[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic rd, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm);
        logic [31:0] off;
        logic [31:0] word;
        logic        err;
        logic        acc;
        int          waited;
        off  = addr - BASE;
        word = off >> 2;
`ifdef ICB_SRAM_RANGE_CHK_EN
        err = (addr < BASE) || (word >= 32'd1024);
`else
        err = 1'b0;
`endif
        word = word & 32'h3FF;
        acc  = !err && (rd || wm != 4'h0);
        s_icb_cmd_valid = 1'b1;
        s_icb_cmd_read  = rd;
        s_icb_cmd_addr  = addr;
        s_icb_cmd_wdata = wd;
        s_icb_cmd_wmask = wm;
        waited = 0;
        @(negedge clk);
        while (!s_icb_cmd_ready && waited < 50) begin
            waited++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        stalls += waited;
        checks++;
        if (!s_icb_cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=0 after %0d cycles required=1", waited);
        end else begin
            if (sram_cs !== acc) begin
                errors++;
                $display("FAIL sram_cs: addr=%h got=%b required=%b", addr, sram_cs, acc);
            end
            if (acc) begin
                checks += 2;
                if (sram_addr !== word[9:0]) begin
                    errors++;
                    $display("FAIL sram_addr: addr=%h got=%0d required=%0d", addr, sram_addr, word[9:0]);
                end
                if (sram_we !== !rd) begin
                    errors++;
                    $display("FAIL sram_we: got=%b required=%b", sram_we, !rd);
                end
                if (!rd) begin
                    checks++;
                    if (sram_wem !== wm || sram_wdata !== wd) begin
                        errors++;
                        $display("FAIL sram_wr: wem=%h wdata=%h required wem=%h wdata=%h",
                                 sram_wem, sram_wdata, wm, wd);
                    end
                    for (int b = 0; b < 4; b++)
                        if (wm[b]) ref_mem[word][b*8 +: 8] = wd[b*8 +: 8];
                end
            end
            sb.push_back({err, (rd && !err) ? ref_mem[word] : 32'h0});
        end
        @(posedge clk); #1;
        s_icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        s_icb_rsp_ready = 1'b1;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: outstanding=%0d required=0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (s_icb_cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cmd_ready: got=%b required=1", s_icb_cmd_ready);
        end
        if (s_icb_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid: got=%b required=0", s_icb_rsp_valid);
        end
        if (sram_cs !== 1'b0) begin
            errors++; $display("FAIL reset_sram_cs: got=%b required=0", sram_cs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        issue(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        drain();
        issue(1'b1, BASE + 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        checks++;
        if (s_icb_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rd_latency_early: rsp_valid=%b required=0", s_icb_rsp_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s_icb_rsp_valid !== 1'b1 || s_icb_rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_latency: valid=%b rdata=%h required valid=1 rdata=deadbeef",
                     s_icb_rsp_valid, s_icb_rsp_rdata);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_byte_mask();
        issue(1'b0, BASE + 32'h20, 32'hAAAA_AAAA, 4'hF);
        issue(1'b0, BASE + 32'h20, 32'h1122_3344, 4'h2);
        issue(1'b1, BASE + 32'h20, 32'h0, 4'h0);
        checks++;
        if (sb[sb.size()-1] !== {1'b0, 32'hAAAA_33AA}) begin
            errors++; $display("FAIL byte_mask_model: got=%h required=0aaaa33aa", sb[sb.size()-1]);
        end
        issue(1'b0, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0);
        issue(1'b1, BASE + 32'h20, 32'h0, 4'h0);
        drain();
    endtask

    task automatic test_backpressure();
        int k;
        for (int i = 0; i < 6; i++)
            issue(1'b0, BASE + 32'h100 + 32'(i * 4), 32'h0B00_0000 + 32'(i), 4'hF);
        drain();
        s_icb_rsp_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            s_icb_cmd_valid = (k < 6);
            s_icb_cmd_read  = 1'b1;
            s_icb_cmd_addr  = BASE + 32'h100 + 32'(k * 4);
            s_icb_cmd_wmask = 4'h0;
            @(negedge clk);
            if (s_icb_cmd_valid && s_icb_cmd_ready) begin
                sb.push_back({1'b0, ref_mem[32'h40 + k]});
                k++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks += 2;
        if (k != 4) begin
            errors++; $display("FAIL bp_accepted: got=%0d required=4", k);
        end
        if (s_icb_cmd_ready !== 1'b0) begin
            errors++; $display("FAIL bp_cmd_ready: got=%b required=0", s_icb_cmd_ready);
        end
        @(posedge clk); #1;
        s_icb_rsp_ready = 1'b1;
        for (int c = 0; c < 30 && k < 6; c++) begin
            s_icb_cmd_valid = 1'b1;
            s_icb_cmd_read  = 1'b1;
            s_icb_cmd_addr  = BASE + 32'h100 + 32'(k * 4);
            @(negedge clk);
            if (s_icb_cmd_ready) begin
                sb.push_back({1'b0, ref_mem[32'h40 + k]});
                k++;
            end
            @(posedge clk); #1;
        end
        s_icb_cmd_valid = 1'b0;
        checks++;
        if (k != 6) begin
            errors++; $display("FAIL bp_remaining: accepted=%0d required=6", k);
        end
        drain();
    endtask

    task automatic test_streaming();
        int w;
        int run;
        for (int i = 0; i < 16; i++)
            issue(1'b0, BASE + 32'h200 + 32'(i * 4), {16'hC0DE, 16'(i)}, 4'hF);
        drain();
        stalls = 0;
        w = 0;
        run = 0;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    issue(1'b1, BASE + 32'h200 + 32'(i * 4), 32'h0, 4'h0);
            end
            begin
                @(negedge clk);
                while (!s_icb_rsp_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                while (s_icb_rsp_valid && run < 20) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        @(posedge clk); #1;
        checks += 2;
        if (stalls != 0) begin
            errors++; $display("FAIL stream_stalls: got=%0d required=0", stalls);
        end
        if (run != 16) begin
            errors++; $display("FAIL stream_run: consecutive=%0d required=16", run);
        end
        drain();
    endtask

    task automatic test_range();
        issue(1'b0, BASE, 32'h5A5A_0000, 4'hF);
        issue(1'b0, BASE + 32'hFFC, 32'h5A5A_03FF, 4'hF);
        drain();
        issue(1'b1, 32'h0000_0FFC, 32'h0, 4'h0);
        issue(1'b1, BASE + 32'd16384, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_0FFC, 32'h1234_5678, 4'hF);
        issue(1'b1, BASE + 32'hFFC, 32'h0, 4'h0);
        drain();
    endtask

    task automatic test_reset_mid();
        int cnt;
        s_icb_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            issue(1'b1, BASE + 32'h200 + 32'(i * 4), 32'h0, 4'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s_icb_rsp_valid !== 1'b1) begin
            errors++; $display("FAIL mid_buffered: rsp_valid=%b required=1", s_icb_rsp_valid);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (s_icb_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_rsp_valid: got=%b required=0", s_icb_rsp_valid);
        end
        if (s_icb_cmd_ready !== 1'b1) begin
            errors++; $display("FAIL mid_rst_cmd_ready: got=%b required=1", s_icb_cmd_ready);
        end
        sb.delete();
        epoch++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_icb_rsp_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (s_icb_rsp_valid) cnt++;
        end
        @(posedge clk); #1;
        checks++;
        if (cnt != 0) begin
            errors++; $display("FAIL stale_rsp: valid_cycles=%0d required=0", cnt);
        end
        issue(1'b1, BASE + 32'h204, 32'h0, 4'h0);
        drain();
    endtask

    initial begin
        rst_n           = 1'b0;
        s_icb_cmd_valid = 1'b0;
        s_icb_cmd_addr  = '0;
        s_icb_cmd_read  = 1'b0;
        s_icb_cmd_wdata = '0;
        s_icb_cmd_wmask = '0;
        s_icb_rsp_ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_write_read();
        test_byte_mask();
        test_backpressure();
        test_streaming();
        test_range();
        test_reset_mid();
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
